// File: rtl/mux_41_conditional.sv
// -----------------------------------------------------------------------------
// mux_41_conditional
//
// Purpose:
//   A 4:1 single-bit multiplexer with a registered observation path.
//   - The combinational output follows in[select] with no clock latency.
//   - One clock later, the output and select are captured into registers.
//   - A saturating counter records how many times the registered output
//     changed value.
//
// Ports:
//   clk        : in  1       rising-edge clock for all registers
//   rst_n      : in  1       asynchronous active-low reset (registers only)
//   in         : in  4       data inputs, bit i chosen when select == i
//   select     : in  2       unsigned index of the chosen data bit
//   out        : out 1       combinational selected bit
//   out_q      : out 1       registered copy of out (1-cycle latency)
//   sel_q      : out 2       registered copy of select (1-cycle latency)
//   toggle_cnt : out CNT_W   saturating count of out_q transitions
// -----------------------------------------------------------------------------
module mux_41_conditional #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       in,
    input  logic [1:0]       select,
    output logic             out,
    output logic             out_q,
    output logic [1:0]       sel_q,
    output logic [CNT_W-1:0] toggle_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    // Increment that sticks at the all-ones value instead of wrapping to 0.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + 1'b1;
    endfunction

    // An unknown select indexes out of range in a 4-state simulator and
    // yields X, so no data bit is silently substituted for a bad select.
    assign out = in[select];

    // The value about to be captured differs from the one currently held.
    // Right after reset out_q is 0, so a first capture of 1 counts.
    logic toggle;
    assign toggle = out ^ out_q;

    // ---- capture stage: out/select sampled, transition counted ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q      <= 1'b0;
            sel_q      <= 2'b00;
            toggle_cnt <= '0;
        end else begin
            out_q <= out;
            sel_q <= select;
            if (toggle) begin
                toggle_cnt <= sat_inc(toggle_cnt);
            end
        end
    end

endmodule

// File: tb/tb_mux_41_conditional.sv
module tb_mux_41_conditional;

    localparam int CNT_W = 8;

    logic             clk;
    logic             clk_en;
    logic             rst_n;
    logic [3:0]       in_s;
    logic [1:0]       sel_s;
    logic             out;
    logic             out_q;
    logic [1:0]       sel_q;
    logic [CNT_W-1:0] toggle_cnt;

    int tests_run;
    int tests_failed;

    typedef struct {
        logic             q;
        logic [1:0]       s;
        logic [CNT_W-1:0] c;
    } exp_t;

    exp_t sb[$];

    // reference register state after the most recently driven edge
    logic             m_q;
    logic [1:0]       m_sel;
    logic [CNT_W-1:0] m_cnt;

    mux_41_conditional #(.CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in         (in_s),
        .select     (sel_s),
        .out        (out),
        .out_q      (out_q),
        .sel_q      (sel_q),
        .toggle_cnt (toggle_cnt)
    );

    // gated clock, period 10 ns; holds low while clk_en is 0
    always begin
        #5;
        if (clk_en) clk = ~clk;
        else        clk = 1'b0;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    function automatic logic ref_mux(input logic [3:0] iv, input logic [1:0] sv);
        case (sv)
            2'b00:   return iv[0];
            2'b01:   return iv[1];
            2'b10:   return iv[2];
            default: return iv[3];
        endcase
    endfunction

    task automatic model_reset();
        m_q   = 1'b0;
        m_sel = 2'b00;
        m_cnt = '0;
        sb.delete();
    endtask

    // drive inputs for the coming edge and push the expected register state
    task automatic drive(input logic [3:0] iv, input logic [1:0] sv);
        exp_t e;
        logic nq;
        in_s  = iv;
        sel_s = sv;
        nq = ref_mux(iv, sv);
        if (nq != m_q && m_cnt != {CNT_W{1'b1}}) m_cnt = m_cnt + 1'b1;
        m_q   = nq;
        m_sel = sv;
        e.q = m_q;
        e.s = m_sel;
        e.c = m_cnt;
        sb.push_back(e);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        in_s  = 4'b0110;
        sel_s = 2'b10;
        #3;
        tests_run++;
        if (out_q !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_out_q: got %b, required 0", out_q);
        end
        tests_run++;
        if (sel_q !== 2'b00) begin
            tests_failed++;
            $display("FAIL reset_sel_q: got %b, required 00", sel_q);
        end
        tests_run++;
        if (toggle_cnt !== '0) begin
            tests_failed++;
            $display("FAIL reset_cnt: got %0d, required 0", toggle_cnt);
        end
        tests_run++;
        if (out !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_out_tracks: got %b, required 1", out);
        end
    endtask

    task automatic test_comb_1001();
        logic [3:0] exp_tbl;
        exp_tbl = 4'b1001;
        in_s = 4'b1001;
        for (int i = 0; i < 4; i++) begin
            sel_s = 2'(i);
            #100;
            tests_run++;
            if (out !== exp_tbl[i]) begin
                tests_failed++;
                $display("FAIL comb_1001 sel=%0d: got %b, required %b", i, out, exp_tbl[i]);
            end
        end
    endtask

    task automatic test_comb_0110();
        logic [3:0] exp_tbl;
        exp_tbl = 4'b0110;
        in_s = 4'b0110;
        for (int i = 0; i < 4; i++) begin
            sel_s = 2'(i);
            #1;
            tests_run++;
            if (out !== exp_tbl[i]) begin
                tests_failed++;
                $display("FAIL comb_0110 sel=%0d: got %b, required %b", i, out, exp_tbl[i]);
            end
        end
    endtask

    task automatic test_capture();
        exp_t e;
        @(negedge clk);
        drive(4'b1001, 2'b00);
        @(posedge clk); #1;
        tests_run++;
        if (sb.size() == 0) begin
            tests_failed++;
            $display("FAIL capture_first: scoreboard empty, required an entry");
        end else begin
            e = sb.pop_front();
            if ({out_q, sel_q, toggle_cnt} !== {e.q, e.s, e.c}) begin
                tests_failed++;
                $display("FAIL capture_first: got q=%b s=%b c=%0d, required q=%b s=%b c=%0d",
                         out_q, sel_q, toggle_cnt, e.q, e.s, e.c);
            end
        end
        tests_run++;
        if (toggle_cnt !== 8'd1) begin
            tests_failed++;
            $display("FAIL capture_first_count: got %0d, required 1", toggle_cnt);
        end
        @(negedge clk);
        drive(4'b1001, 2'b01);
        #1;
        tests_run++;
        if (out !== 1'b0) begin
            tests_failed++;
            $display("FAIL capture_out_immediate: got %b, required 0", out);
        end
        tests_run++;
        if (out_q !== 1'b1 || sel_q !== 2'b00) begin
            tests_failed++;
            $display("FAIL capture_pre_edge: got q=%b s=%b, required q=1 s=00", out_q, sel_q);
        end
        @(posedge clk); #1;
        tests_run++;
        if (sb.size() == 0) begin
            tests_failed++;
            $display("FAIL capture_edge: scoreboard empty, required an entry");
        end else begin
            e = sb.pop_front();
            if ({out_q, sel_q, toggle_cnt} !== {e.q, e.s, e.c}) begin
                tests_failed++;
                $display("FAIL capture_edge: got q=%b s=%b c=%0d, required q=%b s=%b c=%0d",
                         out_q, sel_q, toggle_cnt, e.q, e.s, e.c);
            end
        end
        tests_run++;
        if (out_q !== 1'b0 || sel_q !== 2'b01) begin
            tests_failed++;
            $display("FAIL capture_edge_values: got q=%b s=%b, required q=0 s=01", out_q, sel_q);
        end
    endtask

    task automatic test_reset_mid();
        exp_t e;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            drive(4'b1001, (i % 2 == 1) ? 2'b01 : 2'b00);
            @(posedge clk); #1;
            tests_run++;
            if (sb.size() == 0) begin
                tests_failed++;
                $display("FAIL mid_prep %0d: scoreboard empty, required an entry", i);
            end else begin
                e = sb.pop_front();
                if ({out_q, sel_q, toggle_cnt} !== {e.q, e.s, e.c}) begin
                    tests_failed++;
                    $display("FAIL mid_prep %0d: got q=%b s=%b c=%0d, required q=%b s=%b c=%0d",
                             i, out_q, sel_q, toggle_cnt, e.q, e.s, e.c);
                end
            end
            @(negedge clk);
        end
        tests_run++;
        if (out_q !== 1'b1 || toggle_cnt !== 8'd5) begin
            tests_failed++;
            $display("FAIL mid_precond: got q=%b c=%0d, required q=1 c=5", out_q, toggle_cnt);
        end
        // assert reset between edges and look before the next rising edge
        @(posedge clk); #2;
        // that edge captured sel=00 again (no change), keep the model in step
        rst_n = 1'b0;
        #1;
        tests_run++;
        if (out_q !== 1'b0 || toggle_cnt !== '0 || sel_q !== 2'b00) begin
            tests_failed++;
            $display("FAIL mid_async_clear: got q=%b s=%b c=%0d, required q=0 s=00 c=0",
                     out_q, sel_q, toggle_cnt);
        end
        tests_run++;
        if (out !== ref_mux(in_s, sel_s)) begin
            tests_failed++;
            $display("FAIL mid_out_tracks: got %b, required %b", out, ref_mux(in_s, sel_s));
        end
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        drive(4'b1001, 2'b11);
        @(posedge clk); #1;
        tests_run++;
        if (sb.size() == 0) begin
            tests_failed++;
            $display("FAIL mid_resume: scoreboard empty, required an entry");
        end else begin
            e = sb.pop_front();
            if ({out_q, sel_q, toggle_cnt} !== {e.q, e.s, e.c} || toggle_cnt !== 8'd1) begin
                tests_failed++;
                $display("FAIL mid_resume: got q=%b s=%b c=%0d, required q=%b s=%b c=%0d",
                         out_q, sel_q, toggle_cnt, e.q, e.s, e.c);
            end
        end
    endtask

    task automatic test_x_select();
        exp_t e;
        @(negedge clk);
        sel_s = 2'bxx;
        #1;
        tests_run++;
        if ($isunknown(sel_s)) begin
            if (out !== 1'bx) begin
                tests_failed++;
                $display("FAIL x_select_out: got %b, required x", out);
            end
        end else if (out !== ref_mux(in_s, sel_s)) begin
            tests_failed++;
            $display("FAIL x_select_out: got %b, required %b", out, ref_mux(in_s, sel_s));
        end
        tests_run++;
        if ({out_q, sel_q, toggle_cnt} !== {m_q, m_sel, m_cnt}) begin
            tests_failed++;
            $display("FAIL x_select_hold: got q=%b s=%b c=%0d, required q=%b s=%b c=%0d",
                     out_q, sel_q, toggle_cnt, m_q, m_sel, m_cnt);
        end
        // restore a valid select before the edge
        drive(4'b1001, 2'b01);
        @(posedge clk); #1;
        tests_run++;
        if (sb.size() == 0) begin
            tests_failed++;
            $display("FAIL x_select_after: scoreboard empty, required an entry");
        end else begin
            e = sb.pop_front();
            if ({out_q, sel_q, toggle_cnt} !== {e.q, e.s, e.c}) begin
                tests_failed++;
                $display("FAIL x_select_after: got q=%b s=%b c=%0d, required q=%b s=%b c=%0d",
                         out_q, sel_q, toggle_cnt, e.q, e.s, e.c);
            end
        end
    endtask

    task automatic test_saturate();
        exp_t e;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 303; i++) begin
            // alternate for 300 cycles, then hold select constant
            drive(4'b1001, (i >= 300) ? 2'b01 : ((i % 2 == 1) ? 2'b01 : 2'b00));
            @(posedge clk); #1;
            tests_run++;
            if (sb.size() == 0) begin
                tests_failed++;
                $display("FAIL saturate %0d: scoreboard empty, required an entry", i);
            end else begin
                e = sb.pop_front();
                if ({out_q, sel_q, toggle_cnt} !== {e.q, e.s, e.c}) begin
                    tests_failed++;
                    $display("FAIL saturate %0d: got q=%b s=%b c=%0d, required q=%b s=%b c=%0d",
                             i, out_q, sel_q, toggle_cnt, e.q, e.s, e.c);
                end
            end
            if (i == 299) begin
                tests_run++;
                if (toggle_cnt !== 8'd255) begin
                    tests_failed++;
                    $display("FAIL saturate_max: got %0d, required 255", toggle_cnt);
                end
            end
            @(negedge clk);
        end
        tests_run++;
        if (toggle_cnt !== 8'd255 || out_q !== 1'b0 || sel_q !== 2'b01) begin
            tests_failed++;
            $display("FAIL saturate_hold: got q=%b s=%b c=%0d, required q=0 s=01 c=255",
                     out_q, sel_q, toggle_cnt);
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        clk    = 1'b0;
        clk_en = 1'b0;
        rst_n  = 1'b0;
        in_s   = 4'b0000;
        sel_s  = 2'b00;
        model_reset();
        #10;
        test_reset();
        test_comb_1001();
        test_comb_0110();
        rst_n = 1'b1;
        #10;
        clk_en = 1'b1;
        test_capture();
        test_reset_mid();
        test_x_select();
        test_saturate();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
